// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART state encodings, frame constants and baud helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } uart_state_t;

    // Truncating division; callers must keep the result >= 2.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_baud_tick
// Purpose  : Per-bit tick counter; o_bit_done pulses on the last clock of a bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_bit_done
);

    localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TICK_W-1:0] c_last = TICK_W'(CLKS_PER_BIT - 1);

    logic [TICK_W-1:0] r_count;

    assign o_bit_done = (r_count == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear || o_bit_done) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + TICK_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_tx_engine
// Purpose  : 8N1 UART transmitter with valid/ready input and registered outputs.
//            Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [2:0] c_last_bit = 3'(DATA_BITS - 1);

    uart_state_t          r_state, w_state_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 r_ready, w_ready_nxt;
    logic                 r_busy, w_busy_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [2:0]           r_bit, w_bit_nxt;
    logic                 w_bit_done;
    logic                 w_tick_clear;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity, w_parity_nxt;
`endif

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_tick_clear),
        .o_bit_done (w_bit_done)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_tx_nxt     = r_tx;
        w_ready_nxt  = 1'b0;
        w_busy_nxt   = 1'b1;
        w_shift_nxt  = r_shift;
        w_bit_nxt    = r_bit;
        w_tick_clear = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                // Holding the counter clear keeps the start bit a full bit long.
                w_tick_clear = 1'b1;
                w_tx_nxt     = 1'b1;
                w_ready_nxt  = 1'b1;
                w_busy_nxt   = 1'b0;
                if (valid && r_ready) begin
                    w_state_nxt  = ST_START;
                    w_tx_nxt     = 1'b0;
                    w_ready_nxt  = 1'b0;
                    w_busy_nxt   = 1'b1;
                    w_shift_nxt  = data;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt = ^data;
`endif
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_state_nxt = ST_DATA;
                    w_tx_nxt    = r_shift[0];
                    w_bit_nxt   = 3'd0;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_shift_nxt = r_shift >> 1;
                    w_bit_nxt   = r_bit + 3'd1;
                    w_tx_nxt    = r_shift[1];
                    if (r_bit == c_last_bit) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = ST_PARITY;
                        w_tx_nxt    = r_parity;
`else
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_state_nxt = ST_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_done) begin
                    w_state_nxt = ST_IDLE;
                    w_tx_nxt    = 1'b1;
                    w_ready_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_tx_nxt     = 1'b1;
                w_ready_nxt  = 1'b1;
                w_busy_nxt   = 1'b0;
                w_bit_nxt    = 3'd0;
                w_tick_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_tx     <= 1'b1;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_shift  <= '0;
            r_bit    <= 3'd0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_tx     <= w_tx_nxt;
            r_ready  <= w_ready_nxt;
            r_busy   <= w_busy_nxt;
            r_shift  <= w_shift_nxt;
            r_bit    <= w_bit_nxt;
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parity_nxt;
`endif
        end
    end

    assign tx    = r_tx;
    assign ready = r_ready;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_tx_engine
// Purpose  : Directed self-checking bench for uart_tx_engine (10 clocks/bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_engine;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FC = NB * CPB;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       tx;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_engine #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .tx    (tx),
        .busy  (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Line bits in time order: index 0 is the start bit.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f      = 11'h7FF;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({tx, ready, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_hold {tx,ready,busy}=%b expected 110", {tx, ready, busy});
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if ({tx, ready, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_release {tx,ready,busy}=%b expected 110", {tx, ready, busy});
        end
    endtask

    task automatic test_basic;
        logic [10:0] exp;
        logic [2:0]  e;
        exp   = frame_bits(8'h55);
        data  = 8'h55;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int c = 0; c < FC; c++) begin
            e = {exp[c / CPB], 2'b01};
            n_tests++;
            if ({tx, ready, busy} !== e) begin
                n_fail++;
                $display("FAIL basic_55 cycle %0d {tx,ready,busy}=%b expected %b", c, {tx, ready, busy}, e);
            end
            tick();
        end
        n_tests++;
        if ({tx, ready, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL basic_55_end {tx,ready,busy}=%b expected 110", {tx, ready, busy});
        end
    endtask

    task automatic test_back_to_back;
        logic [10:0] exp;
        logic [2:0]  e;
        exp   = frame_bits(8'h00);
        data  = 8'h00;
        valid = 1'b1;
        tick();
        for (int c = 0; c < FC; c++) begin
            if (c == 30) data = 8'hFF;
            e = {exp[c / CPB], 2'b01};
            n_tests++;
            if ({tx, ready, busy} !== e) begin
                n_fail++;
                $display("FAIL b2b_00 cycle %0d {tx,ready,busy}=%b expected %b", c, {tx, ready, busy}, e);
            end
            tick();
        end
        n_tests++;
        if ({tx, ready, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL b2b_gap {tx,ready,busy}=%b expected 110", {tx, ready, busy});
        end
        tick();
        valid = 1'b0;
        exp   = frame_bits(8'hFF);
        for (int c = 0; c < FC; c++) begin
            e = {exp[c / CPB], 2'b01};
            n_tests++;
            if ({tx, ready, busy} !== e) begin
                n_fail++;
                $display("FAIL b2b_ff cycle %0d {tx,ready,busy}=%b expected %b", c, {tx, ready, busy}, e);
            end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if ({tx, ready, busy} !== 3'b110) begin
                n_fail++;
                $display("FAIL b2b_end cycle %0d {tx,ready,busy}=%b expected 110", c, {tx, ready, busy});
            end
            tick();
        end
    endtask

    task automatic test_ignore_while_busy;
        logic [10:0] exp;
        logic [2:0]  e;
        exp   = frame_bits(8'h96);
        data  = 8'h96;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int c = 0; c < FC; c++) begin
            if (c == 20) begin
                valid = 1'b1;
                data  = 8'hA5;
            end
            if (c == 21) valid = 1'b0;
            e = {exp[c / CPB], 2'b01};
            n_tests++;
            if ({tx, ready, busy} !== e) begin
                n_fail++;
                $display("FAIL ignore_96 cycle %0d {tx,ready,busy}=%b expected %b", c, {tx, ready, busy}, e);
            end
            tick();
        end
        for (int c = 0; c < 20; c++) begin
            n_tests++;
            if ({tx, ready, busy} !== 3'b110) begin
                n_fail++;
                $display("FAIL ignore_after cycle %0d {tx,ready,busy}=%b expected 110", c, {tx, ready, busy});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_frame;
        data  = 8'h3C;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        repeat (35) tick();
        n_tests++;
        if ({ready, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL rstmid_pre {ready,busy}=%b expected 01", {ready, busy});
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({tx, ready, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL rstmid_async {tx,ready,busy}=%b expected 110", {tx, ready, busy});
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            n_tests++;
            if ({tx, ready, busy} !== 3'b110) begin
                n_fail++;
                $display("FAIL rstmid_after cycle %0d {tx,ready,busy}=%b expected 110", c, {tx, ready, busy});
            end
            tick();
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [10:0] exp;
        logic [2:0]  e;
        for (int k = 0; k < 2; k++) begin
            data  = (k == 0) ? 8'h07 : 8'h03;
            exp   = (k == 0) ? 11'b11000001110 : 11'b10000000110;
            valid = 1'b1;
            tick();
            valid = 1'b0;
            for (int c = 0; c < 110; c++) begin
                e = {exp[c / CPB], 2'b01};
                n_tests++;
                if ({tx, ready, busy} !== e) begin
                    n_fail++;
                    $display("FAIL parity_%0d cycle %0d {tx,ready,busy}=%b expected %b", k, c, {tx, ready, busy}, e);
                end
                tick();
            end
            n_tests++;
            if ({tx, ready, busy} !== 3'b110) begin
                n_fail++;
                $display("FAIL parity_%0d_end {tx,ready,busy}=%b expected 110", k, {tx, ready, busy});
            end
            tick();
        end
    endtask
`endif

    task automatic test_idle;
        valid = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            n_tests++;
            if ({tx, busy} !== 2'b10) begin
                n_fail++;
                $display("FAIL idle cycle %0d {tx,busy}=%b expected 10", c, {tx, busy});
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_while_busy();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
